uart_transmit: RTL and testbench

//   8N1/8N2 UART transmitter, LSB first, line idles high. Sends bytes presented on a

---
 rtl/uart_transmit.sv | 161 ++++++++++++++++
 tb/tb_uart_transmit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmit.sv
// uart_transmit
//   8N1/8N2 UART transmitter, LSB first, line idles high. A one-entry holding register
//   lets the upstream queue the next byte mid-frame so frames go out back-to-back.
//
// Parameters
//   CYCLES_PER_BIT  clock cycles per bit period (>= 2)
//   STOP_BITS       number of stop bits (1 or 2)
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_tx_valid   i_tx_byte is valid; transfer on i_tx_valid && o_tx_ready
//   i_tx_byte    byte to send
//   o_tx_ready   holding register empty, a byte may be accepted this cycle
//   o_serial_tx  registered serial line
//   o_tx_busy    high while a frame (start..last stop) is on the line
//   o_tx_done    one-cycle strobe on the final cycle of the last stop bit
module uart_transmit #(
    parameter int unsigned CYCLES_PER_BIT = 217,
    parameter int unsigned STOP_BITS      = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tx_valid,
    input  logic [7:0] i_tx_byte,
    output logic       o_tx_ready,
    output logic       o_serial_tx,
    output logic       o_tx_busy,
    output logic       o_tx_done
);

    localparam int unsigned CW = $clog2(CYCLES_PER_BIT);
    localparam logic [CW-1:0] CYC_LAST = CW'(CYCLES_PER_BIT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [2:0]    bit_q, bit_d;
    logic          stop_q, stop_d;       // index of the stop bit being sent
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_valid_q, hold_valid_d;
    logic          line_q, line_d;

    logic bit_end;
    logic stop_last;
    logic last_stop_cycle;
    logic shifter_free;
    logic xfer;

    assign bit_end         = (cyc_q == CYC_LAST);
    assign stop_last       = (STOP_BITS < 2) || stop_q;
    assign last_stop_cycle = (state_q == StStop) && bit_end && stop_last;
    // The shifter can take a new byte in the same cycle the last stop bit ends,
    // which is what makes consecutive frames contiguous.
    assign shifter_free    = (state_q == StIdle) || last_stop_cycle;
    assign xfer            = i_tx_valid && !hold_valid_q;

    always_comb begin
        state_d      = state_q;
        cyc_d        = bit_end ? '0 : cyc_q + 1'b1;
        bit_d        = bit_q;
        stop_d       = stop_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;

        case (state_q)
            StIdle: begin
                cyc_d = '0;
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    bit_d   = 3'd0;
                end
            end
            StData: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;   // wraps 7 -> 0 on entry to STOP
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                        stop_d  = 1'b0;
                    end
                end
            end
            StStop: begin
                // Only reached for a non-final stop bit; the final one is handled below.
                if (bit_end) begin
                    stop_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cyc_d   = '0;
            end
        endcase

        if (shifter_free) begin
            cyc_d  = '0;
            bit_d  = 3'd0;
            stop_d = 1'b0;
            if (hold_valid_q) begin
                shift_d      = hold_q;
                hold_valid_d = 1'b0;
                state_d      = StStart;
            end else if (xfer) begin
                // Bypass: holding is empty, so load the incoming byte directly.
                shift_d = i_tx_byte;
                state_d = StStart;
            end else begin
                state_d = StIdle;
            end
        end else if (xfer) begin
            hold_d       = i_tx_byte;
            hold_valid_d = 1'b1;
        end

        // Line is registered from the next state so it never glitches.
        case (state_d)
            StStart: line_d = 1'b0;
            StData:  line_d = shift_d[0];
            default: line_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= StIdle;
            cyc_q        <= '0;
            bit_q        <= 3'd0;
            stop_q       <= 1'b0;
            shift_q      <= 8'd0;
            hold_q       <= 8'd0;
            hold_valid_q <= 1'b0;
            line_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            bit_q        <= bit_d;
            stop_q       <= stop_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            line_q       <= line_d;
        end
    end

    assign o_tx_ready  = !hold_valid_q;
    assign o_serial_tx = line_q;
    assign o_tx_busy   = (state_q != StIdle);
    assign o_tx_done   = last_stop_cycle;

endmodule

// File: tb/tb_uart_transmit.sv
module tb_uart_transmit;

    localparam int CPB = 4;
    localparam int CPB2 = 217;

    logic       clk;
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic       ready, line, busy, done;
    logic       valid2;
    logic [7:0] data2;
    logic       ready2, line2, busy2, done2;

    int checks;
    int errors;
    logic [7:0] exp_q[$];

    uart_transmit #(.CYCLES_PER_BIT(CPB), .STOP_BITS(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_tx_valid(valid), .i_tx_byte(data),
        .o_tx_ready(ready), .o_serial_tx(line), .o_tx_busy(busy), .o_tx_done(done)
    );

    uart_transmit #(.CYCLES_PER_BIT(CPB2), .STOP_BITS(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_tx_valid(valid2), .i_tx_byte(data2),
        .o_tx_ready(ready2), .o_serial_tx(line2), .o_tx_busy(busy2), .o_tx_done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Offer a byte, wait for the handshake edge, then record it as expected on the line.
    task automatic push_byte(input logic [7:0] b);
        int n;
        valid = 1'b1;
        data  = b;
        n = 0;
        @(negedge clk);
        while (!ready && n < 1000) begin
            n++;
            @(negedge clk);
        end
        if (!ready) chk("handshake_timeout", 32'(ready), 32'd1);
        @(posedge clk);
        #1;
        valid = 1'b0;
        exp_q.push_back(b);
    endtask

    // Receiver model: mid-bit sampling of the CPB=4 line, compared against the queue.
    logic       rx_active;
    int         rx_cnt;
    logic [9:0] rx_bits;
    initial begin
        rx_active = 1'b0;
        rx_cnt    = 0;
        rx_bits   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rx_active = 1'b0;
            end else if (!rx_active) begin
                if (line == 1'b0) begin
                    rx_active = 1'b1;
                    rx_cnt    = 1;
                end
            end else begin
                rx_cnt++;
                if ((rx_cnt - 1) % CPB == 1) rx_bits[(rx_cnt - 1) / CPB] = line;
                if (rx_cnt == 10 * CPB) begin
                    rx_active = 1'b0;
                    chk("rx_frame_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        chk("rx_data", 32'(rx_bits[8:1]), 32'(exp_q.pop_front()));
                        chk("rx_start", 32'(rx_bits[0]), 32'd0);
                        chk("rx_stop", 32'(rx_bits[9]), 32'd1);
                    end
                end
            end
        end
    end

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // bit 0 = start, 1..8 = data LSB first, 9 = stop
    } vec_t;

    vec_t vecs[5];
    logic [9:0] sf[3];

    initial begin
        int line_err, done_cnt, done_pos, idle_err;
        logic [7:0] rx6;
        logic [1:0] stop6;
        logic [9:0] fr;

        vecs[0] = '{data: 8'hA5, frame: 10'b1_1010_0101_0};
        vecs[1] = '{data: 8'h00, frame: 10'b1_0000_0000_0};
        vecs[2] = '{data: 8'hFF, frame: 10'b1_1111_1111_0};
        vecs[3] = '{data: 8'h01, frame: 10'b1_0000_0001_0};
        vecs[4] = '{data: 8'h80, frame: 10'b1_1000_0000_0};
        sf[0] = 10'b1_0101_0101_0;
        sf[1] = 10'b1_0000_1111_0;
        sf[2] = 10'b1_1111_1111_0;

        checks = 0;
        errors = 0;
        rst    = 1'b1;
        valid  = 1'b0;
        data   = 8'h00;
        valid2 = 1'b0;
        data2  = 8'h00;
        #1;
        chk("rst_line", 32'(line), 32'd1);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle after reset.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("idle_line", 32'(line), 32'd1);
            chk("idle_ready", 32'(ready), 32'd1);
            chk("idle_busy", 32'(busy), 32'd0);
        end

        // Table: single frames from idle, checked cycle by cycle.
        foreach (vecs[v]) begin
            @(posedge clk);
            #1;
            push_byte(vecs[v].data);
            for (int k = 1; k <= 10 * CPB; k++) begin
                @(negedge clk);
                chk("frame_line", 32'(line), 32'(vecs[v].frame[(k - 1) / CPB]));
                chk("frame_done", 32'(done), 32'(k == 10 * CPB));
                chk("frame_busy", 32'(busy), 32'd1);
            end
            @(negedge clk);
            chk("frame_busy_fall", 32'(busy), 32'd0);
            chk("frame_done_after", 32'(done), 32'd0);
        end

        // Back-to-back stream of three bytes.
        repeat (3) @(posedge clk);
        #1;
        done_cnt = 0;
        fork
            begin
                push_byte(8'h55);
                push_byte(8'h0F);
                push_byte(8'hFF);
            end
            begin
                @(posedge clk);
                for (int k = 1; k <= 30 * CPB; k++) begin
                    @(negedge clk);
                    fr = sf[(k - 1) / (10 * CPB)];
                    chk("stream_line", 32'(line), 32'(fr[((k - 1) % (10 * CPB)) / CPB]));
                    chk("stream_busy", 32'(busy), 32'd1);
                    if (done) done_cnt++;
                    if (k == 20 || k == 60) chk("stream_ready_held", 32'(ready), 32'd0);
                end
                @(negedge clk);
                chk("stream_busy_fall", 32'(busy), 32'd0);
            end
        join
        chk("stream_done_count", 32'(done_cnt), 32'd3);

        // Bypass on the final stop cycle.
        repeat (3) @(posedge clk);
        #1;
        push_byte(8'h12);
        repeat (39) @(posedge clk);
        #1;
        valid = 1'b1;
        data  = 8'h3C;
        @(negedge clk);
        chk("bypass_pre_done", 32'(done), 32'd1);
        chk("bypass_pre_ready", 32'(ready), 32'd1);
        @(posedge clk);
        #1;
        valid = 1'b0;
        exp_q.push_back(8'h3C);
        @(negedge clk);
        chk("bypass_start", 32'(line), 32'd0);
        chk("bypass_busy", 32'(busy), 32'd1);
        chk("bypass_ready", 32'(ready), 32'd1);
        repeat (45) @(posedge clk);
        @(negedge clk);
        chk("bypass_idle", 32'(busy), 32'd0);

        // Async reset mid-DATA with a byte held.
        @(posedge clk);
        #1;
        push_byte(8'h00);
        push_byte(8'h7E);
        repeat (10) @(posedge clk);
        #1;
        chk("prerst_line", 32'(line), 32'd0);
        chk("prerst_ready", 32'(ready), 32'd0);
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("midrst_line", 32'(line), 32'd1);
        chk("midrst_ready", 32'(ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle_err = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (line !== 1'b1 || busy !== 1'b0) idle_err++;
        end
        chk("postrst_quiet", 32'(idle_err), 32'd0);

        // 2 stop bits, 217 cycles per bit, byte 0x00.
        @(negedge clk);
        chk("d2_ready", 32'(ready2), 32'd1);
        @(posedge clk);
        #1;
        valid2 = 1'b1;
        data2  = 8'h00;
        @(posedge clk);
        #1;
        valid2   = 1'b0;
        line_err = 0;
        done_cnt = 0;
        done_pos = 0;
        rx6      = 8'hFF;
        stop6    = 2'b00;
        for (int k = 1; k <= 11 * CPB2; k++) begin
            @(negedge clk);
            if (line2 !== ((k <= 9 * CPB2) ? 1'b0 : 1'b1)) line_err++;
            if (done2) begin
                done_cnt++;
                done_pos = k;
            end
            if ((k - 1) % CPB2 == CPB2 / 2) begin
                if ((k - 1) / CPB2 >= 1 && (k - 1) / CPB2 <= 8) rx6[(k - 1) / CPB2 - 1] = line2;
                if ((k - 1) / CPB2 >= 9) stop6[(k - 1) / CPB2 - 9] = line2;
            end
            if (k == 11 * CPB2) chk("d2_busy_last", 32'(busy2), 32'd1);
        end
        chk("d2_line", 32'(line_err), 32'd0);
        chk("d2_done_count", 32'(done_cnt), 32'd1);
        chk("d2_done_pos", 32'(done_pos), 32'(11 * CPB2));
        chk("d2_rx_data", 32'(rx6), 32'h00);
        chk("d2_rx_stop", 32'(stop6), 32'h3);
        @(negedge clk);
        chk("d2_busy_fall", 32'(busy2), 32'd0);

        repeat (5) @(posedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
